// File: rtl/backtrack_controller.sv
// Conflict backtracker for the DPLL trace stack.
// Ports: clock/reset, start/busy/done/unsat,
//   backtrack_count, ext_* push request in,
//   tt_* trace table command/response,
//   va_* variable-table clear/set.
module backtrack_controller #(
   parameter int NUM_VARIABLE     = 128,
   parameter int VARIABLE_INDEXES = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      unsat,
   output logic [VARIABLE_INDEXES:0] backtrack_count,
   input  logic                      ext_push,
   input  logic                      ext_type,
   input  logic                      ext_val,
   input  logic [VARIABLE_INDEXES:0] ext_variable,
   output logic                      ext_ready,
   output logic                      tt_en,
   output logic                      tt_rw,
   output logic                      tt_type,
   output logic                      tt_val,
   output logic [VARIABLE_INDEXES:0] tt_variable,
   input  logic                      tt_type_out,
   input  logic                      tt_val_out,
   input  logic [VARIABLE_INDEXES:0] tt_variable_out,
   input  logic                      tt_empty,
   output logic                      va_clear,
   output logic                      va_set,
   output logic [VARIABLE_INDEXES:0] va_variable,
   output logic                      va_value
);

   localparam int W = VARIABLE_INDEXES + 1;

   // The index must be wide enough to name
   // every variable the stack can hold.
   if (NUM_VARIABLE > (2 ** W)) begin : g_bad
      $error("index too narrow for stack");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP_REQ,
      S_POP_WAIT,
      S_PUSH_FLIP,
      S_DONE,
      S_UNSAT
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [W-1:0]   r_count;
   logic [W-1:0]   r_var;
   logic           r_val;
   logic           w_accept;
   logic           w_go;
   logic           w_decide;

   assign w_go     = (r_state == S_IDLE) & start;
   assign w_decide = (r_state == S_POP_WAIT)
                   & ~tt_type_out;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_var   <= '0;
         r_val   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_go) begin
            r_count <= '0;
         end else if (r_state == S_POP_WAIT &&
                      r_count != '1) begin
            r_count <= r_count + 1'b1;
         end
         // Keep the decision flipped, ready to push.
         if (w_decide) begin
            r_var <= tt_variable_out;
            r_val <= ~tt_val_out;
         end
      end
   end

   assign backtrack_count = r_count;
   assign busy = (r_state != S_IDLE);

   // Gated by reset so a held external request
   // cannot reach the trace table during reset.
   assign w_accept = reset & ext_push & ~start;

   always_comb begin
      w_next      = r_state;
      done        = 1'b0;
      unsat       = 1'b0;
      ext_ready   = 1'b0;
      tt_en       = 1'b0;
      tt_rw       = 1'b0;
      tt_type     = 1'b0;
      tt_val      = 1'b0;
      tt_variable = '0;
      va_clear    = 1'b0;
      va_set      = 1'b0;
      va_variable = '0;
      va_value    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            ext_ready   = w_accept;
            tt_en       = w_accept;
            tt_rw       = reset;
            tt_type     = ext_type & reset;
            tt_val      = ext_val & reset;
            tt_variable = ext_variable
                        & {W{reset}};
            if (start) begin
               w_next = tt_empty ? S_UNSAT
                                 : S_POP_REQ;
            end
         end
         S_POP_REQ: begin
            tt_en  = 1'b1;
            tt_rw  = 1'b0;
            w_next = S_POP_WAIT;
         end
         S_POP_WAIT: begin
            va_clear    = 1'b1;
            va_variable = tt_variable_out;
            if (!tt_type_out) begin
               w_next = S_PUSH_FLIP;
            end else if (tt_empty) begin
               w_next = S_UNSAT;
            end else begin
               w_next = S_POP_REQ;
            end
         end
         S_PUSH_FLIP: begin
            tt_en       = 1'b1;
            tt_rw       = 1'b1;
            tt_type     = 1'b1;
            tt_val      = r_val;
            tt_variable = r_var;
            va_set      = 1'b1;
            va_variable = r_var;
            va_value    = r_val;
            w_next      = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         S_UNSAT: begin
            unsat  = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_backtrack_controller.sv
// Bench for backtrack_controller.
// Trace stack is a queue; expectations from a stack walk.
module tb_backtrack_controller;

   localparam int BUDGET = 4000;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       busy, done, unsat;
   logic [8:0] backtrack_count;
   logic       ext_push, ext_type, ext_val;
   logic [8:0] ext_variable;
   logic       ext_ready;
   logic       tt_en, tt_rw, tt_type, tt_val;
   logic [8:0] tt_variable;
   logic       tt_type_out, tt_val_out;
   logic [8:0] tt_variable_out;
   logic       tt_empty = 1'b1;
   logic       va_clear, va_set;
   logic [8:0] va_variable;
   logic       va_value;

   logic [10:0] stk[$];
   logic [10:0] tto = '0;
   logic        clr_req = 1'b0;
   int          checks = 0;
   int          errors = 0;

   assign tt_type_out     = tto[10];
   assign tt_val_out      = tto[9];
   assign tt_variable_out = tto[8:0];

   always #5 clock = ~clock;

   backtrack_controller dut (
      .clock(clock), .reset(reset),
      .start(start), .busy(busy),
      .done(done), .unsat(unsat),
      .backtrack_count(backtrack_count),
      .ext_push(ext_push), .ext_type(ext_type),
      .ext_val(ext_val),
      .ext_variable(ext_variable),
      .ext_ready(ext_ready),
      .tt_en(tt_en), .tt_rw(tt_rw),
      .tt_type(tt_type), .tt_val(tt_val),
      .tt_variable(tt_variable),
      .tt_type_out(tt_type_out),
      .tt_val_out(tt_val_out),
      .tt_variable_out(tt_variable_out),
      .tt_empty(tt_empty),
      .va_clear(va_clear), .va_set(va_set),
      .va_variable(va_variable),
      .va_value(va_value)
   );

   // Trace table: pop result and empty flag
   // appear one cycle after the command.
   always @(posedge clock) begin
      if (clr_req) begin
         stk.delete();
      end else if (tt_en && tt_rw) begin
         stk.push_back({tt_type, tt_val, tt_variable});
      end else if (tt_en && !tt_rw && stk.size() > 0) begin
         tto <= stk.pop_back();
      end
      tt_empty <= (stk.size() == 0);
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic load(input string nm,
                       input logic [10:0] ent[$]);
      int bad;
      bad = 0;
      clr_req = 1'b1;
      @(negedge clock);
      clr_req = 1'b0;
      foreach (ent[i]) begin
         ext_push     = 1'b1;
         ext_type     = ent[i][10];
         ext_val      = ent[i][9];
         ext_variable = ent[i][8:0];
         #1;
         if ({ext_ready, tt_en, tt_rw, tt_type,
              tt_val, tt_variable} !== {3'b111, ent[i]})
            bad++;
         @(negedge clock);
      end
      ext_push = 1'b0;
      chk({nm, ":load_pass"}, bad, 0);
   endtask

   task automatic run_bt(input string nm);
      logic [10:0] snap[$];
      logic [10:0] e;
      logic [10:0] exp_push, got_push;
      logic [9:0]  got_set;
      int exp_clr[$];
      int got_clr[$];
      int pops, exp_cyc, exp_cnt, exp_size;
      int cyc, end_cyc, npush, nset, npop;
      int both, extbad, mism;
      bit exp_done, got_done, got_unsat;
      snap = stk;
      exp_done = 0;
      exp_push = '0;
      pops = 0;
      while (snap.size() > 0) begin
         e = snap.pop_back();
         pops++;
         exp_clr.push_back(int'(e[8:0]));
         if (!e[10]) begin
            exp_done = 1;
            exp_push = {1'b1, ~e[9], e[8:0]};
            break;
         end
      end
      exp_size = exp_done ? snap.size() + 1 : 0;
      exp_cyc  = exp_done ? 2 * pops + 2 : 2 * pops + 1;
      exp_cnt  = (pops > 511) ? 511 : pops;
      got_push = '0;
      got_set  = '0;
      end_cyc = 0; npush = 0; nset = 0; npop = 0;
      both = 0; extbad = 0;
      got_done = 0; got_unsat = 0;
      start = 1'b1;
      #1;
      chk({nm, ":start_ready"}, ext_ready, 0);
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      while (cyc <= BUDGET && !got_done && !got_unsat) begin
         if (va_clear) got_clr.push_back(int'(va_variable));
         if (va_clear && va_set) both++;
         if (ext_ready) extbad++;
         if (tt_en && tt_rw) begin
            npush++;
            got_push = {tt_type, tt_val, tt_variable};
         end
         if (va_set) begin
            nset++;
            got_set = {va_value, va_variable};
         end
         if (tt_en && !tt_rw) npop++;
         if (done) begin
            got_done = 1; end_cyc = cyc;
         end
         if (unsat) begin
            got_unsat = 1; end_cyc = cyc;
         end
         if (!got_done && !got_unsat) begin
            @(negedge clock);
            cyc++;
         end
      end
      chk({nm, ":finished"}, got_done | got_unsat, 1);
      chk({nm, ":done"}, got_done, exp_done);
      chk({nm, ":unsat"}, got_unsat, !exp_done);
      chk({nm, ":cycle"}, end_cyc, exp_cyc);
      chk({nm, ":count"}, backtrack_count, exp_cnt);
      chk({nm, ":pops"}, npop, pops);
      chk({nm, ":nclear"}, got_clr.size(), exp_clr.size());
      mism = 0;
      foreach (exp_clr[i])
         if (i >= got_clr.size() || got_clr[i] != exp_clr[i])
            mism++;
      chk({nm, ":clr_order"}, mism, 0);
      chk({nm, ":npush"}, npush, exp_done ? 1 : 0);
      chk({nm, ":push"}, got_push, exp_push);
      chk({nm, ":nset"}, nset, exp_done ? 1 : 0);
      chk({nm, ":set"}, got_set, exp_push[9:0]);
      chk({nm, ":clr_set"}, both, 0);
      chk({nm, ":ext_held"}, extbad, 0);
      @(negedge clock);
      chk({nm, ":idle"}, busy, 0);
      chk({nm, ":hold_cnt"}, backtrack_count, exp_cnt);
      chk({nm, ":stack"}, stk.size(), exp_size);
   endtask

   initial begin
      logic [10:0] q[$];
      int bad, n;
      reset = 1'b0; start = 1'b0;
      ext_push = 1'b0; ext_type = 1'b0;
      ext_val = 1'b0; ext_variable = '0;
      #3;
      chk("rst_ctl", {busy, done, unsat, tt_en, tt_rw,
                      va_clear, va_set, ext_ready}, 0);
      chk("rst_cnt", backtrack_count, 0);
      chk("rst_data", {tt_type, tt_val, tt_variable,
                       va_variable, va_value}, 0);
      @(negedge clock);
      reset = 1'b1;

      q = '{{1'b0, 1'b1, 9'd3}};
      load("single", q);
      run_bt("single");

      q = '{{1'b0, 1'b1, 9'd5}, {1'b1, 1'b0, 9'd7},
            {1'b1, 1'b1, 9'd9}};
      load("multi", q);
      run_bt("multi");

      q = '{{1'b1, 1'b1, 9'd2}, {1'b1, 1'b0, 9'd4}};
      load("forced", q);
      run_bt("forced");

      q.delete();
      load("empty", q);
      run_bt("empty");

      q = '{{1'b0, 1'b1, 9'd3}, {1'b1, 1'b1, 9'd6}};
      load("arb", q);
      ext_push = 1'b1; ext_type = 1'b0;
      ext_val = 1'b1; ext_variable = 9'd42;
      run_bt("arb");
      chk("arb:accept", ext_ready, 1);
      chk("arb:pass", {tt_en, tt_rw, tt_type, tt_val,
                       tt_variable}, {4'b1101, 9'd42});
      @(negedge clock);
      ext_push = 1'b0;
      chk("arb:size", stk.size(), 2);
      chk("arb:top", stk[stk.size() - 1],
          {1'b0, 1'b1, 9'd42});

      q = '{{1'b0, 1'b1, 9'd5}, {1'b1, 1'b0, 9'd7},
            {1'b1, 1'b1, 9'd9}};
      load("rstmid", q);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("rstmid:in_wait", {busy, va_clear}, 2'b11);
      reset = 1'b0;
      #1;
      chk("rstmid:ctl", {busy, done, unsat, tt_en, tt_rw,
                         va_clear, va_set, ext_ready}, 0);
      chk("rstmid:cnt", backtrack_count, 0);
      chk("rstmid:data", {tt_type, tt_val, tt_variable,
                          va_variable, va_value}, 0);
      @(negedge clock);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (tt_en || busy) bad++;
         @(negedge clock);
      end
      chk("rstmid:quiet", bad, 0);

      for (int it = 0; it < 25; it++) begin
         q.delete();
         n = $urandom_range(0, 8);
         for (int j = 0; j < n; j++)
            q.push_back({($urandom_range(0, 3) != 0),
                         1'($urandom),
                         9'($urandom_range(0, 511))});
         load($sformatf("rnd%0d", it), q);
         run_bt($sformatf("rnd%0d", it));
      end

      q.delete();
      for (int j = 0; j < 520; j++)
         q.push_back({1'b1, 1'(j), 9'(j)});
      load("sat", q);
      run_bt("sat");

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
